// File: rtl/pwm_sdm_dac_stage.sv
// DAC output stage: scales incoming samples with saturation, buffers them in a small FIFO,
// and turns one sample per frame into a 1-bit PWM or first-order sigma-delta stream.
module pwm_sdm_dac_stage #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          mode,
  input  logic [3:0]                    gain,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          dac_out,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          clr_underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W-1:0] FRAME_LAST = {DATA_W{1'b1}} - DATA_W'(1);
  localparam logic [DATA_W-1:0] DUTY_RST   = DATA_W'(1) << (DATA_W - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [DATA_W-1:0] cnt, acc, duty;
  logic              mode_q;

  logic [DATA_W+3:0] prod;
  logic [DATA_W+4:0] rounded;
  logic [DATA_W+1:0] shifted;
  logic [DATA_W-1:0] scaled;
  logic [DATA_W:0]   sdm_sum;
  logic              push, pop, boundary;

  // Q1.3 gain with round-half-up, saturated to full scale before storage.
  assign prod    = {4'b0000, s_data} * {{DATA_W{1'b0}}, gain};
  assign rounded = {1'b0, prod} + (DATA_W+5)'(4);
  assign shifted = rounded[DATA_W+4:3];
  assign scaled  = (|shifted[DATA_W+1:DATA_W]) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];

  // Valid/ready: a sample transfers on any edge where s_valid && s_ready. s_ready is derived
  // from the registered level only, so a full FIFO refuses data even on a pop edge.
  assign s_ready    = (level != LVL_FULL) && !rst;
  assign push       = s_valid && s_ready;
  assign boundary   = en && (cnt == FRAME_LAST);
  assign pop        = boundary && (level != '0);
  assign sdm_sum    = {1'b0, acc} + {1'b0, duty};
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= scaled;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      cnt         <= '0;
      acc         <= '0;
      duty        <= DUTY_RST;
      mode_q      <= 1'b0;
      dac_out     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      // A new underrun event outranks a coincident clear.
      if (boundary && (level == '0)) underrun <= 1'b1;
      else if (clr_underrun)         underrun <= 1'b0;

      if (en) begin
        cnt         <= boundary ? '0 : cnt + DATA_W'(1);
        frame_start <= (cnt == '0);
        dac_out     <= mode_q ? sdm_sum[DATA_W] : (cnt < duty);
        if (mode_q) acc <= sdm_sum[DATA_W-1:0];
        if (boundary) begin
          if (pop) duty <= mem[rd_ptr];
          mode_q <= mode;
          if (mode != mode_q) acc <= '0;
        end
      end else begin
        dac_out     <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_sdm_dac_stage.sv
// Bench for pwm_sdm_dac_stage: a frame monitor counts PWM high cycles per frame and checks them
// against expected duties queued by the stimulus; directed SDM, pause and reset scenarios follow.
module tb_pwm_sdm_dac_stage;
  localparam int W = 8;
  localparam int FRAME = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] gain = 4'd8;
  logic [W-1:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       dac_out;
  logic       frame_start;
  logic [2:0] fifo_level;
  logic       underrun;
  logic       clr_underrun = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit   mon_on = 1'b0;
  bit   in_frame = 1'b0;
  int   mon_ones = 0;
  int   mon_len = 0;
  int   last_len = 0;
  bit   feed_on = 1'b0;

  pwm_sdm_dac_stage #(.DATA_W(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .gain(gain),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dac_out(dac_out), .frame_start(frame_start), .fifo_level(fifo_level),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model and helpers ----------------
  function automatic int ref_scale(input int d, input int g);
    int p;
    p = (d * g + 4) / 8;
    return (p > 255) ? 255 : p;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input int n);
    for (int i = 0; i < n; i++) begin
      int b;
      b = 0;
      do begin
        @(negedge clk);
        b++;
      end while (!frame_start && b < 700);
      if (!frame_start) begin
        checks++;
        errors++;
        $display("FAIL frame_start_timeout: got none within %0d cycles expected a pulse", b);
      end
      tick();
    end
  endtask

  task automatic push_sample(input int d, input int g);
    int b;
    b = 0;
    while (!s_ready && b < 700) begin
      tick();
      b++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got s_ready=0 expected 1 within 700 cycles");
    end else begin
      s_valid = 1'b1;
      s_data  = W'(d);
      gain    = 4'(g);
      exp_q.push_back(W'(ref_scale(d, g)));
      tick();
      s_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; gain = 4'd8;
    s_valid = 1'b0; clr_underrun = 1'b0;
    tick();
    tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_dac_out", dac_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 1);
  endtask

  // ---------------- frame monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!mon_on) begin
      in_frame = 1'b0;
    end else if (frame_start) begin
      if (in_frame) begin
        last_len = mon_len;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got frame with %0d highs expected no frame", mon_ones);
        end else begin
          check("frame_high_count", mon_ones, int'(exp_q.pop_front()));
        end
      end
      in_frame = 1'b1;
      mon_ones = int'(dac_out);
      mon_len  = 1;
    end else if (in_frame) begin
      mon_ones += int'(dac_out);
      mon_len++;
    end
  end

  // ---------------- SDM feeder ----------------
  always @(posedge clk) begin
    if (feed_on) begin
      #1;
      if (feed_on && s_ready) begin
        s_valid = 1'b1;
        s_data  = W'(64);
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ones, ncyc, b, sdm_seen;

    // Test 1: idle PWM frames at reset duty, underrun and its clear
    do_reset();
    mon_on = 1'b1;
    exp_q.push_back(W'(128));
    exp_q.push_back(W'(128));
    en = 1'b1;
    wait_fs(1);
    repeat (10) tick();
    check("t1_underrun_before_boundary", underrun, 0);
    wait_fs(1);
    check("t1_underrun_after_boundary", underrun, 1);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    check("t1_underrun_cleared", underrun, 0);
    wait_fs(1);

    // Test 2: fill FIFO, full backpressure, drain one sample per frame
    do_reset();
    mon_on = 1'b1;
    exp_q.push_back(W'(128));
    push_sample(0, 8);
    push_sample(255, 8);
    push_sample(64, 8);
    push_sample(200, 8);
    check("t2_s_ready_full", s_ready, 0);
    s_valid = 1'b1;
    s_data  = W'(9);
    tick();
    s_valid = 1'b0;
    check("t2_level_full", fifo_level, 4);
    en = 1'b1;
    wait_fs(1);
    check("t2_level_frame1", fifo_level, 4);
    for (int k = 0; k < 4; k++) begin
      wait_fs(1);
      check("t2_level_after_boundary", fifo_level, 3 - k);
    end
    wait_fs(1);
    check("t2_underrun_after_drain", underrun, 1);

    // Test 3: scaling corners plus randomised samples/gains, FIFO kept fed
    do_reset();
    mon_on = 1'b1;
    exp_q.push_back(W'(128));
    en = 1'b1;
    push_sample(200, 15);
    push_sample(100, 4);
    push_sample(3, 1);
    push_sample(5, 1);
    push_sample(77, 0);
    for (int i = 0; i < 6; i++) push_sample($urandom_range(0, 255), $urandom_range(0, 15));
    check("t3_no_underrun", underrun, 0);
    b = 0;
    while (exp_q.size() != 0 && b < 4000) begin
      tick();
      b++;
    end
    check("t3_all_frames_seen", exp_q.size(), 0);
    mon_on = 1'b0;

    // Test 4: SDM density from acc=0, then mode change takes effect at next boundary
    do_reset();
    mode = 1'b1;
    en = 1'b1;
    feed_on = 1'b1;
    wait_fs(1);
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!frame_start && b < 700);
    ones = int'(dac_out);
    ncyc = 1;
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      ones += int'(dac_out);
      ncyc++;
    end
    check("t4_sdm_window0", ones, 64);
    repeat ($urandom_range(1, 30)) begin
      @(negedge clk);
      ncyc++;
    end
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ones += int'(dac_out);
      ncyc++;
    end
    check("t4_sdm_window_offset", ones, 64);
    mode = 1'b0;
    sdm_seen = ncyc;
    ones = 0;
    b = 0;
    while (b < 700) begin
      @(negedge clk);
      b++;
      if (frame_start) break;
      ones += int'(dac_out);
      ncyc++;
    end
    check("t4_sdm_until_boundary_cycles", ncyc, 3 * FRAME);
    check("t4_sdm_until_boundary_ones", ones, (3 * FRAME) / 4 - sdm_seen / 4);
    ones = int'(dac_out);
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      ones += int'(dac_out);
    end
    check("t4_pwm_after_toggle", ones, 64);
    feed_on = 1'b0;
    tick();
    s_valid = 1'b0;

    // Test 5: pause mid-frame, push during pause, coincident underrun set/clear
    do_reset();
    mon_on = 1'b1;
    exp_q.push_back(W'(128));
    en = 1'b1;
    wait_fs(1);
    repeat (50) tick();
    en = 1'b0;
    tick();
    check("t5_pause_dac_out", dac_out, 0);
    check("t5_pause_frame_start", frame_start, 0);
    check("t5_pause_level_before", fifo_level, 0);
    s_valid = 1'b1;
    s_data  = W'(100);
    gain    = 4'd8;
    exp_q.push_back(W'(ref_scale(100, 8)));
    tick();
    s_valid = 1'b0;
    check("t5_pause_push_level", fifo_level, 1);
    repeat (8) tick();
    check("t5_pause_dac_out_end", dac_out, 0);
    en = 1'b1;
    wait_fs(1);
    check("t5_frame_len_with_pause", last_len, FRAME + 10);
    check("t5_popped_at_boundary", fifo_level, 0);
    check("t5_no_underrun", underrun, 0);
    repeat (252) tick();
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    check("t5_set_wins_over_clear", underrun, 1);
    wait_fs(1);
    check("t5_underrun_sticky", underrun, 1);

    // Test 6: one-cycle reset mid-frame with a partly full FIFO
    do_reset();
    push_sample(10, 8);
    push_sample(20, 8);
    push_sample(30, 8);
    exp_q.delete();
    en = 1'b1;
    repeat (20) tick();
    check("t6_level_before_rst", fifo_level, 3);
    rst = 1'b1;
    #1;
    check("t6_s_ready_in_rst", s_ready, 0);
    tick();
    check("t6_level_after_rst", fifo_level, 0);
    check("t6_dac_after_rst", dac_out, 0);
    check("t6_fs_after_rst", frame_start, 0);
    rst = 1'b0;
    #1;
    check("t6_s_ready_after_rst", s_ready, 1);
    mon_on = 1'b1;
    exp_q.push_back(W'(128));
    wait_fs(2);
    mon_on = 1'b0;

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
